// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the line_memory block: line width, the slice of the
// byte address that selects a line, the default request latency and the
// request FSM state type.
// ----------------------------------------------------------------------------
package mem_pkg;

    localparam int MEM_LINE_BITS   = 256;
    // Line index is taken from addr[IDX_HI:IDX_LO]; bits below IDX_LO select a
    // byte inside the 32-byte line and are ignored.
    localparam int IDX_HI          = 13;
    localparam int IDX_LO          = 5;
    localparam int IDX_W           = IDX_HI - IDX_LO + 1;
    localparam int DEFAULT_LATENCY = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/line_memory_array.sv
// ----------------------------------------------------------------------------
// line_memory_array
// Single-port LINES x LINE_BITS storage with a synchronous write and a
// combinational read of the addressed line. The storage is deliberately not
// reset so a bench can preload and inspect it through `memory[]`.
//
// Ports:
//   clk_i    in   clock, write on rising edge
//   we_i     in   write enable
//   idx_i    in   line index (shared by read and write)
//   wdata_i  in   line to write
//   rdata_o  out  line currently addressed by idx_i
// ----------------------------------------------------------------------------
module line_memory_array
    import mem_pkg::*;
#(
    parameter int LINES     = 512,
    parameter int LINE_BITS = MEM_LINE_BITS,
    parameter int AW        = IDX_W
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        idx_i,
    input  logic [LINE_BITS-1:0] wdata_i,
    output logic [LINE_BITS-1:0] rdata_o
);

    logic [LINE_BITS-1:0] memory [LINES];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            memory[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = memory[idx_i];

endmodule

// File: rtl/line_memory.sv
// ----------------------------------------------------------------------------
// line_memory
// Off-chip data memory model behind the dcache controller. Each request moves
// one cache line over an enable/write/ack handshake with a fixed latency:
// a request accepted on edge N is acknowledged with a one-cycle ack_o pulse
// between edges N+LATENCY-1 and N+LATENCY.
//
// Ports:
//   clk_i     in   clock
//   rst_i     in   asynchronous active-low reset (storage is not reset)
//   addr_i    in   byte address, line index = addr_i[13:5]
//   data_i    in   write line
//   enable_i  in   request valid, must be held until ack_o is seen
//   write_i   in   1 = write line, 0 = read line
//   ack_o     out  one-cycle completion pulse
//   data_o    out  read line, held until the next read completes
//   err_o     out  out-of-range flag, pulses with ack_o
//
// Build option:
//   LINE_MEMORY_RANGE_CHECK_EN - when defined, requests with any address bit
//   above bit 13 set are flagged: err_o pulses with ack_o, writes are dropped
//   and reads return zero. When undefined, err_o stays 0 and high address
//   bits alias modulo 16 KB.
// ----------------------------------------------------------------------------
module line_memory
    import mem_pkg::*;
#(
    parameter int LINES     = 512,
    parameter int LINE_BITS = MEM_LINE_BITS,
    parameter int LATENCY   = DEFAULT_LATENCY,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [LINE_BITS-1:0] data_i,
    input  logic                 enable_i,
    input  logic                 write_i,
    output logic                 ack_o,
    output logic [LINE_BITS-1:0] data_o,
    output logic                 err_o
);

    // Counter must reach LATENCY on the completion edge without wrapping.
    localparam int                CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LATENCY - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic                 write_q, write_d;
    logic                 oor_q, oor_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic [LINE_BITS-1:0] data_q, data_d;

    logic                 mem_we;
    logic [LINE_BITS-1:0] mem_rdata;
    logic                 oor_req;

`ifdef LINE_MEMORY_RANGE_CHECK_EN
    assign oor_req = |addr_i[ADDR_W-1:IDX_HI+1];
`else
    // Without the range check the flag path is constant zero, so err_o is
    // tied low and the upper address bits simply alias.
    assign oor_req = 1'b0;
`endif

    // Byte-offset bits never matter; upper bits matter only with range check.
    logic unused_addr;
    assign unused_addr = ^{addr_i[IDX_LO-1:0], addr_i[ADDR_W-1:IDX_HI+1]};

    line_memory_array #(
        .LINES     (LINES),
        .LINE_BITS (LINE_BITS),
        .AW        (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        write_d = write_q;
        oor_d   = oor_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        data_d  = data_q;
        mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    // All request fields are captured here; later input
                    // activity cannot affect the in-flight request.
                    state_d = WAIT;
                    cnt_d   = CNT_ONE;
                    idx_d   = addr_i[IDX_HI:IDX_LO];
                    wdata_d = data_i;
                    write_d = write_i;
                    oor_d   = oor_req;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    err_d   = oor_q;
                    if (write_q) begin
                        mem_we = !oor_q;
                    end else begin
                        data_d = oor_q ? '0 : mem_rdata;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            oor_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            oor_q   <= oor_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign ack_o  = ack_q;
    assign err_o  = err_q;
    assign data_o = data_q;

endmodule

// File: tb/tb_line_memory.sv
// ----------------------------------------------------------------------------
// tb_line_memory
// Self-checking bench for line_memory. A reference model keeps the expected
// contents of every line as a plain array, indexed by (address / 32) mod 512,
// and predicts read data, err and the fixed request latency.
// ----------------------------------------------------------------------------
module tb_line_memory;

    localparam int LAT     = 10;
    localparam int NLINES  = 512;
    localparam int LB      = 256;

    localparam logic [LB-1:0] PAT1  = 256'h8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff_1111_2222_3333_4444_5555_6666_7777_0000;
    localparam logic [LB-1:0] PAT16 = 256'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [LB-1:0] ECFA  = {16{16'hecfa}};

    logic          clk;
    logic          rst_n;
    logic [31:0]   addr;
    logic [LB-1:0] wdata;
    logic          en;
    logic          wr;
    logic          ack;
    logic [LB-1:0] rdata;
    logic          err;

    int total;
    int bad;

    logic [LB-1:0] ref_mem [NLINES];
    logic [LB-1:0] exp_dout;

    line_memory #(
        .LINES     (NLINES),
        .LINE_BITS (LB),
        .LATENCY   (LAT),
        .ADDR_W    (32)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .addr_i   (addr),
        .data_i   (wdata),
        .enable_i (en),
        .write_i  (wr),
        .ack_o    (ack),
        .data_o   (rdata),
        .err_o    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] v;
        v = '0;
        for (int k = 0; k < LB / 32; k++) v = {v[LB-33:0], 32'($urandom())};
        return v;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a / 32) % NLINES);
    endfunction

    function automatic bit out_of_range(input logic [31:0] a);
`ifdef LINE_MEMORY_RANGE_CHECK_EN
        return a >= 32'h4000;
`else
        return 1'b0;
`endif
    endfunction

    // Issues one request from just after a rising edge; returns the number of
    // edges from acceptance to the first ack sample, the data/err seen with
    // ack, and ack one cycle later.
    task automatic do_req(input logic [31:0] a, input logic [LB-1:0] d, input logic w,
                          input bit churn, output int lat, output logic [LB-1:0] rd,
                          output logic er, output logic ack_after);
        addr = a; wdata = d; wr = w; en = 1'b1;
        @(posedge clk); #1;
        en  = 1'b0;
        lat = 0;
        while (ack !== 1'b1 && lat < 4 * LAT) begin
            if (churn) begin
                addr  = $urandom();
                wdata = rand_line();
                wr    = 1'($urandom_range(0, 1));
                en    = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata;
        er = err;
        en = 1'b0;
        @(posedge clk); #1;
        ack_after = ack;
    endtask

    task automatic test_reset();
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", ack); end
        total++; if (rdata !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", rdata); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    endtask

    task automatic test_read();
        int lat; logic [LB-1:0] rd; logic er, aa;
        do_req(32'h20, rand_line(), 1'b0, 1'b0, lat, rd, er, aa);
        exp_dout = ref_mem[1];
        total++; if (lat !== LAT - 1) begin bad++; $display("FAIL read_latency got=%0d want=%0d", lat, LAT - 1); end
        total++; if (rd !== PAT1) begin bad++; $display("FAIL read_data got=%h want=%h", rd, PAT1); end
        total++; if (aa !== 1'b0) begin bad++; $display("FAIL read_ack_clear got=%b want=0", aa); end
    endtask

    task automatic test_write_read();
        int lat; logic [LB-1:0] rd; logic er, aa;
        do_req(32'h240, ECFA, 1'b1, 1'b0, lat, rd, er, aa);
        ref_mem[18] = ECFA;
        total++; if (lat !== LAT - 1) begin bad++; $display("FAIL wr_latency got=%0d want=%0d", lat, LAT - 1); end
        total++; if (dut.u_array.memory[18] !== ECFA) begin bad++; $display("FAIL wr_commit got=%h want=%h", dut.u_array.memory[18], ECFA); end
        total++; if (rd !== exp_dout) begin bad++; $display("FAIL wr_dout_hold got=%h want=%h", rd, exp_dout); end
        do_req(32'h240, rand_line(), 1'b0, 1'b0, lat, rd, er, aa);
        exp_dout = ECFA;
        total++; if (rd !== ECFA) begin bad++; $display("FAIL wr_readback got=%h want=%h", rd, ECFA); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (rdata !== ECFA) begin bad++; $display("FAIL dout_hold got=%h want=%h", rdata, ECFA); end
    endtask

    task automatic test_back_to_back();
        int c, t1, t2;
        logic [LB-1:0] d, rd2;
        d = rand_line();
        addr = 32'h400; wdata = d; wr = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        c = 0; t1 = -1; t2 = -1; rd2 = '0;
        while (t2 < 0 && c < 4 * LAT) begin
            @(posedge clk); #1;
            c++;
            if (ack === 1'b1) begin
                if (t1 < 0) begin
                    t1 = c;
                    addr = 32'h200; wr = 1'b0; wdata = rand_line();
                end else begin
                    t2 = c;
                    rd2 = rdata;
                end
            end
        end
        en = 1'b0;
        @(posedge clk); #1;
        ref_mem[32] = d;
        exp_dout = ref_mem[16];
        total++; if (t1 !== LAT - 1) begin bad++; $display("FAIL b2b_first_ack got=%0d want=%0d", t1, LAT - 1); end
        total++; if (t2 - t1 !== LAT + 1) begin bad++; $display("FAIL b2b_spacing got=%0d want=%0d", t2 - t1, LAT + 1); end
        total++; if (rd2 !== PAT16) begin bad++; $display("FAIL b2b_read got=%h want=%h", rd2, PAT16); end
        total++; if (dut.u_array.memory[32] !== d) begin bad++; $display("FAIL b2b_write got=%h want=%h", dut.u_array.memory[32], d); end
    endtask

    task automatic test_churn();
        int lat, extra; logic [LB-1:0] d, rd; logic er, aa;
        d = rand_line();
        do_req(32'h0000_0c60, d, 1'b1, 1'b1, lat, rd, er, aa);
        ref_mem[99] = d;
        total++; if (lat !== LAT - 1) begin bad++; $display("FAIL churn_wr_latency got=%0d want=%0d", lat, LAT - 1); end
        total++; if (dut.u_array.memory[99] !== d) begin bad++; $display("FAIL churn_wr_line got=%h want=%h", dut.u_array.memory[99], d); end
        do_req(32'h0000_0020, rand_line(), 1'b0, 1'b1, lat, rd, er, aa);
        exp_dout = ref_mem[1];
        total++; if (rd !== ref_mem[1]) begin bad++; $display("FAIL churn_rd_line got=%h want=%h", rd, ref_mem[1]); end
        extra = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL churn_extra_ack got=%0d want=0", extra); end
    endtask

    task automatic test_reset_mid();
        int acks, lat; logic [LB-1:0] prev, rd; logic er, aa;
        prev = ref_mem[34];
        acks = 0;
        addr = 32'h440; wdata = ~prev; wr = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) acks++;
        end
        #3 rst_n = 1'b0;
        #1;
        total++; if (dut.state_q !== mem_pkg::IDLE) begin bad++; $display("FAIL rstmid_state got=%0d want=%0d", dut.state_q, mem_pkg::IDLE); end
        total++; if (rdata !== '0) begin bad++; $display("FAIL rstmid_data got=%h want=0", rdata); end
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < LAT + 3; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) acks++;
        end
        exp_dout = '0;
        total++; if (acks !== 0) begin bad++; $display("FAIL rstmid_ack got=%0d want=0", acks); end
        total++; if (dut.u_array.memory[34] !== prev) begin bad++; $display("FAIL rstmid_mem got=%h want=%h", dut.u_array.memory[34], prev); end
        do_req(32'h440, rand_line(), 1'b0, 1'b0, lat, rd, er, aa);
        exp_dout = prev;
        total++; if (lat !== LAT - 1) begin bad++; $display("FAIL rstmid_after_latency got=%0d want=%0d", lat, LAT - 1); end
        total++; if (rd !== prev) begin bad++; $display("FAIL rstmid_after_data got=%h want=%h", rd, prev); end
    endtask

    task automatic test_random();
        int lat, idx; logic [LB-1:0] d, rd; logic er, aa, w, oor;
        logic [31:0] a;
        for (int n = 0; n < 24; n++) begin
`ifdef LINE_MEMORY_RANGE_CHECK_EN
            if ($urandom_range(0, 3) == 0) a = $urandom() | 32'h0000_4000;
            else a = 32'($urandom_range(0, 16383));
`else
            a = $urandom();
`endif
            w   = 1'($urandom_range(0, 1));
            d   = rand_line();
            idx = line_of(a);
            oor = out_of_range(a);
            do_req(a, d, w, 1'b0, lat, rd, er, aa);
            if (w) begin
                if (!oor) ref_mem[idx] = d;
            end else begin
                exp_dout = oor ? '0 : ref_mem[idx];
            end
            total++; if (lat !== LAT - 1) begin bad++; $display("FAIL rand_latency n=%0d got=%0d want=%0d", n, lat, LAT - 1); end
            total++; if (er !== oor) begin bad++; $display("FAIL rand_err n=%0d got=%b want=%b", n, er, oor); end
            total++; if (rd !== exp_dout) begin bad++; $display("FAIL rand_data n=%0d got=%h want=%h", n, rd, exp_dout); end
        end
    endtask

`ifdef LINE_MEMORY_RANGE_CHECK_EN
    task automatic test_range();
        int lat; logic [LB-1:0] rd; logic er, aa;
        do_req(32'h0001_0000, rand_line(), 1'b1, 1'b0, lat, rd, er, aa);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL range_wr_err got=%b want=1", er); end
        total++; if (lat !== LAT - 1) begin bad++; $display("FAIL range_latency got=%0d want=%0d", lat, LAT - 1); end
        total++; if (dut.u_array.memory[0] !== ref_mem[0]) begin bad++; $display("FAIL range_mem0 got=%h want=%h", dut.u_array.memory[0], ref_mem[0]); end
        total++; if (aa !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL range_pulse got=%b%b want=00", aa, err); end
        do_req(32'h0001_0020, rand_line(), 1'b0, 1'b0, lat, rd, er, aa);
        exp_dout = '0;
        total++; if (er !== 1'b1) begin bad++; $display("FAIL range_rd_err got=%b want=1", er); end
        total++; if (rd !== '0) begin bad++; $display("FAIL range_rd_data got=%h want=0", rd); end
    endtask
`endif

    task automatic test_final_contents();
        int diffs;
        diffs = 0;
        for (int i = 0; i < NLINES; i++) begin
            if (dut.u_array.memory[i] !== ref_mem[i]) diffs++;
        end
        total++; if (diffs !== 0) begin bad++; $display("FAIL final_contents lines_differing=%0d want=0", diffs); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        exp_dout = '0;
        #1 rst_n = 1'b0;
        for (int i = 0; i < NLINES; i++) begin
            ref_mem[i] = rand_line();
        end
        ref_mem[1]  = PAT1;
        ref_mem[16] = PAT16;
        for (int i = 0; i < NLINES; i++) begin
            dut.u_array.memory[i] = ref_mem[i];
        end
        #1;
        test_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        test_read();
        test_write_read();
        test_back_to_back();
        test_churn();
        test_reset_mid();
        test_random();
`ifdef LINE_MEMORY_RANGE_CHECK_EN
        test_range();
`endif
        test_final_contents();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_memory.md
Name: line_memory

Overview:
- Off-chip data memory model for the project-2 CPU. Sits directly downstream of the dcache controller and services its line-granular fills and write-backs.
- Each request moves one 256-bit cache line over a single-request enable/write/ack handshake with fixed multi-cycle latency.
- The backing array is exposed hierarchically as `memory[]` for bench preload and flush.

Parameters:
- LINES, 512, number of 256-bit lines (16 KB).
- LINE_BITS, 256, line width in bits.
- LATENCY, 10, cycles from request acceptance edge to ack edge; legal range >= 2.
- ADDR_W, 32, byte address width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- addr_i  in  ADDR_W  byte address; line index = addr_i[13:5]; addr_i[4:0] ignored.
- data_i  in  LINE_BITS  write line.
- enable_i  in  1  request valid.
- write_i  in  1  1 = write line, 0 = read line.
- ack_o  out  1  one-cycle completion pulse.
- data_o  out  LINE_BITS  read line, valid while ack_o=1.
- err_o  out  1  out-of-range flag; present only with the optional feature, tied 0 otherwise.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, counter=0, ack_o=0, data_o=0, err_o=0.
  - Latched address, data and write bit cleared.
  - memory[] is NOT reset; contents are preserved for bench preload.
- IDLE:
  - On a rising edge with enable_i=1, latch addr_i[13:5], data_i and write_i, set counter=1, go to WAIT.
  - With enable_i=0, stay in IDLE.
- WAIT:
  - counter increments each edge.
  - On the edge where counter==LATENCY-1, go to ACK.
  - On that same edge, a write commits memory[idx] <= latched data, and a read registers data_o <= memory[idx].
  - Input changes during WAIT are ignored because all request fields were latched at acceptance.
- ACK:
  - ack_o=1 for exactly one cycle.
  - The next edge returns to IDLE and clears ack_o.
  - data_o holds its value until the next read completes.
- Latency: ack_o is high in the LATENCY-th cycle after the acceptance edge. With LATENCY=10, a request accepted at edge N gives ack_o=1 between edges N+9 and N+10.
- Back-to-back requests: if enable_i is still 1 in the IDLE cycle after ACK, a new request is accepted. This supports the dcache write-back-then-allocate sequence.
  - Minimum spacing between acks is LATENCY+1 cycles.
- enable_i seen during WAIT or ACK is not queued; the requester must hold enable_i until it observes ack_o.
- A write followed by a read of the same line returns the new data.
- Reset mid-operation: the in-flight request is dropped; no write commits and ack_o is not asserted.
- Address arithmetic: index = addr_i[13:5] (9 bits). Addresses 0x4000 and above alias modulo 16 KB unless the optional feature is compiled in.

Optional Feature:
- Macro: LINE_MEMORY_RANGE_CHECK_EN.
- Defined:
  - A request with addr_i[ADDR_W-1:14] != 0 is flagged out-of-range at acceptance.
  - On its ack, err_o=1 for the same single cycle.
  - A flagged write is suppressed (memory unchanged).
  - A flagged read returns data_o=0.
  - Latency is unchanged.
- Undefined: err_o is tied 0 and high address bits alias.

Decomposition:
- Shared package `mem_pkg`, holding:
  - State enum {IDLE, WAIT, ACK}.
  - LINE_BITS, the index slice bounds (13:5) and the default latency constant.
- One natural sub-module: `line_memory_array`, a single-port synchronous LINES x LINE_BITS array with a write enable. It holds the `memory[]` array, which must keep that exact name for hierarchical access by the bench.
- The FSM and latency counter stay in the top.

Test Plan:
1. Read, memory[1] preloaded with 0x8888_9999..._0000: enable_i=1, write_i=0, addr_i=0x20 accepted at edge 0 -> ack_o=1 only in cycle 9, data_o = memory[1] value, ack_o=0 in cycle 10.
2. Write then read: write data_i = all 0xECFA to addr_i=0x240, then read addr_i=0x240 -> read data_o = ECFA pattern, and memory[18] equals it after the first ack.
3. Back-to-back: enable_i held high across a write to 0x400 and a read from 0x200 -> acks 11 cycles apart, read returns memory[16] = 0x0123_4567...3210.
4. Mid-request churn: addr_i and data_i changed every cycle during WAIT -> the original latched line is written or read, and no extra ack occurs.
5. Reset: rst_i driven low at cycle 5 of a write to 0x440 -> memory[34] unchanged, ack_o never asserted, FSM in IDLE; a request issued after reset completes normally.
6. With LINE_MEMORY_RANGE_CHECK_EN defined: write to 0x0001_0000 -> err_o=1 together with ack_o, and memory[0] unchanged.
